// File: rtl/branch_metric_unit_if.sv
// Symbol-in / metrics-out bus of the branch metric unit, with DUT-side (slave) and driver-side (master) views.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1; no combinational path from valid to ready.
interface branch_metric_unit_if #(
    parameter int CODE_N = 2,
    parameter int SOFT_W = 3,
    parameter int CNT_W  = 16
);
    localparam int METRIC_W = $clog2(CODE_N * (2**SOFT_W - 1) + 1);

    logic [CODE_N*SOFT_W-1:0]         i_data;
    logic [CODE_N-1:0]                i_erase;
    logic                             i_valid;
    logic                             o_ready;
    logic [(2**CODE_N)*METRIC_W-1:0]  o_metrics;
    logic                             o_valid;
    logic                             i_ready;
    logic [CNT_W-1:0]                 o_sym_cnt;

    modport slave (
        input  i_data, i_erase, i_valid, i_ready,
        output o_ready, o_metrics, o_valid, o_sym_cnt
    );

    modport master (
        output i_data, i_erase, i_valid, i_ready,
        input  o_ready, o_metrics, o_valid, o_sym_cnt
    );
endinterface

// File: rtl/branch_metric_unit.sv
// Branch metric unit: soft-decision distance of one received symbol to every codeword, with per-bit erasure.
// Define BMU_NORMALIZE_EN to add a third stage that subtracts the minimum metric from all metrics.
module branch_metric_unit #(
    parameter int CODE_N = 2,
    parameter int SOFT_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    branch_metric_unit_if.slave bus
);
    localparam int METRIC_W = $clog2(CODE_N * (2**SOFT_W - 1) + 1);
    localparam int NCW      = 2**CODE_N;
    localparam int PAD_W    = METRIC_W - SOFT_W;

    logic                           w_en;
    logic                           w_accept;
    logic                           w_out_valid;
    logic                           r_v1;
    logic [CODE_N-1:0][SOFT_W-1:0]  r_d0;
    logic [CODE_N-1:0][SOFT_W-1:0]  r_d1;
    logic                           r_v2;
    logic [NCW-1:0][METRIC_W-1:0]   w_sum;
    logic [NCW-1:0][METRIC_W-1:0]   r_m2;
    logic [CNT_W-1:0]               r_cnt;

    assign w_en     = !w_out_valid || bus.i_ready;
    assign w_accept = bus.i_valid && w_en;

    // Distance to an expected 0 is the sample; to an expected 1 it is MAXS - sample, i.e. its complement.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_v1 <= 1'b0;
            r_d0 <= '0;
            r_d1 <= '0;
        end else if (w_en) begin
            r_v1 <= w_accept;
            if (bus.i_valid) begin
                for (int j = 0; j < CODE_N; j++) begin
                    if (bus.i_erase[j]) begin
                        r_d0[j] <= '0;
                        r_d1[j] <= '0;
                    end else begin
                        r_d0[j] <= bus.i_data[j*SOFT_W +: SOFT_W];
                        r_d1[j] <= ~bus.i_data[j*SOFT_W +: SOFT_W];
                    end
                end
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NCW; k++) begin
            for (int j = 0; j < CODE_N; j++) begin
                if (((k >> j) & 1) != 0)
                    w_sum[k] = w_sum[k] + {{PAD_W{1'b0}}, r_d1[j]};
                else
                    w_sum[k] = w_sum[k] + {{PAD_W{1'b0}}, r_d0[j]};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_v2 <= 1'b0;
            r_m2 <= '0;
        end else if (w_en) begin
            r_v2 <= r_v1;
            if (r_v1)
                r_m2 <= w_sum;
        end
    end

`ifdef BMU_NORMALIZE_EN
    logic [METRIC_W-1:0]          w_min;
    logic                         r_v3;
    logic [NCW-1:0][METRIC_W-1:0] r_m3;

    always_comb begin
        w_min = r_m2[0];
        for (int k = 1; k < NCW; k++) begin
            if (r_m2[k] < w_min)
                w_min = r_m2[k];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_v3 <= 1'b0;
            r_m3 <= '0;
        end else if (w_en) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                for (int k = 0; k < NCW; k++)
                    r_m3[k] <= r_m2[k] - w_min;
            end
        end
    end

    assign w_out_valid   = r_v3;
    assign bus.o_metrics = r_m3;
`else
    assign w_out_valid   = r_v2;
    assign bus.o_metrics = r_m2;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (w_out_valid && bus.i_ready)
            r_cnt <= r_cnt + 1'b1;
    end

    assign bus.o_valid   = w_out_valid;
    assign bus.o_ready   = w_en;
    assign bus.o_sym_cnt = r_cnt;
endmodule

// File: tb/tb_branch_metric_unit.sv
// Bench for branch_metric_unit: default soft instance plus a hard-decision (SOFT_W=1, CNT_W=4) instance.
// Honours BMU_NORMALIZE_EN in its reference model and latency expectations.
module tb_branch_metric_unit;
    localparam int MW = 4;
    localparam int MV = 4 * MW;
`ifdef BMU_NORMALIZE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_metric_unit_if #(.CODE_N(2), .SOFT_W(3), .CNT_W(16)) bus ();
    branch_metric_unit_if #(.CODE_N(2), .SOFT_W(1), .CNT_W(4))  hbus ();

    branch_metric_unit #(.CODE_N(2), .SOFT_W(3), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
    );
    branch_metric_unit #(.CODE_N(2), .SOFT_W(1), .CNT_W(4)) dut_h (
        .i_clk(clk), .i_rst_n(rst_n), .bus(hbus)
    );

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: metric(k) = sum of per-bit distances, erased bits contribute 0, optional min subtraction.
    function automatic logic [63:0] ref_metrics(input int cn, input int sw, input int mw,
                                               input logic [15:0] data, input logic [3:0] erase);
        int maxs;
        int s;
        int mn;
        int m[16];
        logic [63:0] r;
        maxs = (1 << sw) - 1;
        mn = 1 << 30;
        r = '0;
        for (int k = 0; k < (1 << cn); k++) begin
            m[k] = 0;
            for (int j = 0; j < cn; j++) begin
                s = int'((data >> (j * sw)) & 16'(maxs));
                if (!erase[j])
                    m[k] += (((k >> j) & 1) != 0) ? (maxs - s) : s;
            end
            if (m[k] < mn) mn = m[k];
        end
        for (int k = 0; k < (1 << cn); k++) begin
`ifdef BMU_NORMALIZE_EN
            m[k] -= mn;
`endif
            r |= 64'(m[k]) << (k * mw);
        end
        return r;
    endfunction

    // Scoreboard for the default instance: push on accept, pop and compare on delivery.
    logic [MV-1:0] exp_q[$];
    logic [15:0]   exp_cnt = '0;
    logic          prev_stall = 1'b0;
    logic [MV-1:0] prev_m = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt = '0;
            prev_stall = 1'b0;
        end else begin
            check("sym_cnt", 64'(bus.o_sym_cnt), 64'(exp_cnt));
            check("o_ready_rule", 64'(bus.o_ready), 64'(!bus.o_valid || bus.i_ready));
            if (prev_stall) begin
                check("stall_hold_valid", 64'(bus.o_valid), 64'(1));
                check("stall_hold_metrics", 64'(bus.o_metrics), 64'(prev_m));
            end
            if (bus.o_valid && bus.i_ready) begin
                if (exp_q.size() == 0)
                    check("spurious_valid", 64'(bus.o_valid), 64'(0));
                else
                    check("metrics", 64'(bus.o_metrics), 64'(exp_q.pop_front()));
                exp_cnt = exp_cnt + 16'd1;
            end
            prev_stall = bus.o_valid && !bus.i_ready;
            prev_m = bus.o_metrics;
            if (bus.i_valid && bus.o_ready)
                exp_q.push_back(MV'(ref_metrics(2, 3, MW, 16'(bus.i_data), 4'(bus.i_erase))));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nv;
        int runs;
        int sent;
        logic prev_v;
        logic saw_stall;
        logic held;
        logic [63:0] exp_dir;

        bus.i_data = '0; bus.i_erase = '0; bus.i_valid = 1'b0; bus.i_ready = 1'b1;
        hbus.i_data = '0; hbus.i_erase = '0; hbus.i_valid = 1'b0; hbus.i_ready = 1'b1;

        // Reset and reset values
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_o_valid", 64'(bus.o_valid), 64'(0));
        check("rst_o_metrics", 64'(bus.o_metrics), 64'(0));
        check("rst_o_sym_cnt", 64'(bus.o_sym_cnt), 64'(0));
        check("rst_o_ready", 64'(bus.o_ready), 64'(1));
        check("rst_h_o_valid", 64'(hbus.o_valid), 64'(0));

        // Hard decision: data 01 -> {1,2,0,1}
        hbus.i_data = 2'b01; hbus.i_valid = 1'b1;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            hbus.i_valid = 1'b0;
            lat++;
            if (hbus.o_valid) break;
        end
        check("hard_latency", 64'(lat), 64'(LAT));
        check("hard_metrics", 64'(hbus.o_metrics), 64'(8'b01_10_00_01));

        // 16 more hard symbols: 17 total wraps the 4-bit counter to 1
        for (int i = 0; i < 16; i++) begin
            hbus.i_data = 2'($urandom_range(0, 3)); hbus.i_valid = 1'b1;
            @(posedge clk); #1;
        end
        hbus.i_valid = 1'b0;
        repeat (LAT + 2) @(posedge clk);
        #1 check("hard_cnt_wrap", 64'(hbus.o_sym_cnt), 64'(1));

        // Soft samples bit0=7, bit1=2, no erasure
`ifdef BMU_NORMALIZE_EN
        exp_dir = 64'({4'd3, 4'd10, 4'd0, 4'd7});
`else
        exp_dir = 64'({4'd5, 4'd12, 4'd2, 4'd9});
`endif
        bus.i_data = {3'd2, 3'd7}; bus.i_erase = 2'b00; bus.i_valid = 1'b1;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.i_valid = 1'b0;
            lat++;
            if (bus.o_valid) break;
        end
        check("soft_latency", 64'(lat), 64'(LAT));
        check("soft_metrics", 64'(bus.o_metrics), exp_dir);

        // Same samples with bit1 erased
        bus.i_erase = 2'b10; bus.i_valid = 1'b1;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.i_valid = 1'b0;
            lat++;
            if (bus.o_valid) break;
        end
        check("erase_latency", 64'(lat), 64'(LAT));
        check("erase_metrics", 64'(bus.o_metrics), 64'({4'd0, 4'd7, 4'd0, 4'd7}));
        bus.i_erase = 2'b00;

        // Fresh counter, then 8 back-to-back symbols
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        nv = 0; runs = 0; prev_v = 1'b0;
        for (int i = 0; i < 14; i++) begin
            bus.i_valid = (i < 8);
            bus.i_data = 6'($urandom_range(0, 63));
            bus.i_erase = 2'($urandom_range(0, 3));
            @(negedge clk);
            if (bus.o_valid) begin
                nv++;
                if (!prev_v) runs++;
            end
            prev_v = bus.o_valid;
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        check("stream_valid_cycles", 64'(nv), 64'(8));
        check("stream_single_run", 64'(runs), 64'(1));
        check("stream_sym_cnt", 64'(bus.o_sym_cnt), 64'(8));

        // Downstream stall for 5 cycles in the middle of a 12-symbol stream
        sent = 0; saw_stall = 1'b0; held = 1'b0;
        for (int c = 0; c < 30; c++) begin
            bus.i_ready = !(c >= 4 && c < 9);
            bus.i_valid = (sent < 12);
            if (!held) bus.i_data = 6'($urandom_range(0, 63));
            @(negedge clk);
            if (!bus.o_ready) saw_stall = 1'b1;
            held = bus.i_valid && !bus.o_ready;
            if (bus.i_valid && bus.o_ready) sent++;
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0; bus.i_ready = 1'b1;
        check("stall_o_ready_dropped", 64'(saw_stall), 64'(1));
        check("stall_all_sent", 64'(sent), 64'(12));
        check("stall_drained", 64'(exp_q.size()), 64'(0));
        check("stall_sym_cnt", 64'(bus.o_sym_cnt), 64'(20));

        // Two symbols in flight (downstream blocked), then a one-cycle reset
        bus.i_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.i_valid = 1'b1; bus.i_data = 6'($urandom_range(0, 63));
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; bus.i_ready = 1'b1;
        check("flush_o_ready", 64'(bus.o_ready), 64'(1));
        check("flush_sym_cnt", 64'(bus.o_sym_cnt), 64'(0));
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.o_valid) nv++;
        end
        check("flush_no_valid", 64'(nv), 64'(0));
        @(posedge clk); #1;

        // Random traffic with random backpressure
        for (int c = 0; c < 80; c++) begin
            bus.i_valid = ($urandom_range(0, 3) != 0);
            bus.i_ready = ($urandom_range(0, 2) != 0);
            bus.i_data = 6'($urandom_range(0, 63));
            bus.i_erase = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0; bus.i_ready = 1'b1;
        repeat (LAT + 3) @(posedge clk);
        #1 check("random_drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
